// File: rtl/ro_pair_measure_ctrl.sv
// Ring-oscillator pair measurement sequencer: routes a challenge pair onto the two edge
// counters, runs a fixed enable window, then compares the counts into a response bit.
module ro_pair_measure_ctrl #(
    parameter int unsigned N_RO    = 16,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned CLR_CYC = 4,
    parameter int unsigned WINDOW  = 50000,
    parameter int unsigned SETTLE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] chal_a,
    input  logic [SEL_W-1:0] chal_b,
    output logic             busy,
    output logic [SEL_W-1:0] sel_a,
    output logic [SEL_W-1:0] sel_b,
    output logic [N_RO-1:0]  ro_en,
    output logic             cnt_rst,
    input  logic [CNT_W-1:0] count_a,
    input  logic [CNT_W-1:0] count_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_bit,
    output logic             resp_tie,
    output logic [CNT_W-1:0] resp_diff,
    output logic             resp_err
);

    localparam int unsigned MaxA   = (CLR_CYC > WINDOW) ? CLR_CYC : WINDOW;
    localparam int unsigned MaxCyc = (MaxA > SETTLE) ? MaxA : SETTLE;
    localparam int unsigned TW     = $clog2(MaxCyc + 1);

    // Timer counts down to zero, so each phase loads its length minus one.
    localparam logic [TW-1:0] ClrLoad = TW'(CLR_CYC - 1);
    localparam logic [TW-1:0] WinLoad = TW'(WINDOW - 1);
    localparam logic [TW-1:0] SetLoad = TW'(SETTLE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StMeasure,
        StSettle,
        StCompare,
        StResp
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [SEL_W-1:0] sel_a_q, sel_a_d;
    logic [SEL_W-1:0] sel_b_q, sel_b_d;
    logic             pend_err_q, pend_err_d;
    logic             resp_bit_q, resp_bit_d;
    logic             resp_tie_q, resp_tie_d;
    logic [CNT_W-1:0] resp_diff_q, resp_diff_d;
    logic             resp_err_q, resp_err_d;
    logic             chal_ok;

    assign chal_ok = (chal_a != chal_b) && (32'(chal_a) < N_RO) && (32'(chal_b) < N_RO);

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        sel_a_d     = sel_a_q;
        sel_b_d     = sel_b_q;
        pend_err_d  = pend_err_q;
        resp_bit_d  = resp_bit_q;
        resp_tie_d  = resp_tie_q;
        resp_diff_d = resp_diff_q;
        resp_err_d  = resp_err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sel_a_d    = chal_a;
                    sel_b_d    = chal_b;
                    pend_err_d = !chal_ok;
                    tmr_d      = ClrLoad;
                    // A rejected challenge still spends one cycle in COMPARE to form
                    // its error response, so both paths share the same response step.
                    state_d    = chal_ok ? StClear : StCompare;
                end
            end
            StClear: begin
                if (tmr_q == '0) begin
                    state_d = StMeasure;
                    tmr_d   = WinLoad;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            StMeasure: begin
                if (tmr_q == '0) begin
                    state_d = StSettle;
                    tmr_d   = SetLoad;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            StSettle: begin
                if (tmr_q == '0) begin
                    state_d = StCompare;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            StCompare: begin
                resp_err_d = pend_err_q;
                if (pend_err_q) begin
                    resp_bit_d  = 1'b0;
                    resp_tie_d  = 1'b0;
                    resp_diff_d = '0;
                end else begin
                    resp_bit_d  = count_a > count_b;
                    resp_tie_d  = count_a == count_b;
                    resp_diff_d = (count_a >= count_b) ? (count_a - count_b)
                                                       : (count_b - count_a);
                end
                state_d = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tmr_q       <= '0;
            sel_a_q     <= '0;
            sel_b_q     <= '0;
            pend_err_q  <= 1'b0;
            resp_bit_q  <= 1'b0;
            resp_tie_q  <= 1'b0;
            resp_diff_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            pend_err_q  <= pend_err_d;
            resp_bit_q  <= resp_bit_d;
            resp_tie_q  <= resp_tie_d;
            resp_diff_q <= resp_diff_d;
            resp_err_q  <= resp_err_d;
        end
    end

    always_comb begin
        busy       = state_q != StIdle;
        cnt_rst    = (state_q == StIdle) || (state_q == StClear);
        resp_valid = state_q == StResp;
        ro_en      = '0;
        if (state_q == StMeasure) begin
            ro_en = (N_RO'(1) << sel_a_q) | (N_RO'(1) << sel_b_q);
        end
    end

    assign sel_a     = sel_a_q;
    assign sel_b     = sel_b_q;
    assign resp_bit  = resp_bit_q;
    assign resp_tie  = resp_tie_q;
    assign resp_diff = resp_diff_q;
    assign resp_err  = resp_err_q;

endmodule

// File: tb/tb_ro_pair_measure_ctrl.sv
// Directed bench for ro_pair_measure_ctrl with a short window and constant counter values.
module tb_ro_pair_measure_ctrl;

    localparam int unsigned N_RO    = 16;
    localparam int unsigned SEL_W   = 5;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned CLR_CYC = 4;
    localparam int unsigned WINDOW  = 100;
    localparam int unsigned SETTLE  = 4;
    localparam int          LAT     = CLR_CYC + WINDOW + SETTLE + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [SEL_W-1:0] chal_a, chal_b;
    logic             busy;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic [N_RO-1:0]  ro_en;
    logic             cnt_rst;
    logic [CNT_W-1:0] count_a, count_b;
    logic             resp_valid, resp_ready;
    logic             resp_bit, resp_tie, resp_err;
    logic [CNT_W-1:0] resp_diff;

    int n_total = 0;
    int n_bad   = 0;

    ro_pair_measure_ctrl #(
        .N_RO   (N_RO),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W),
        .CLR_CYC(CLR_CYC),
        .WINDOW (WINDOW),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .chal_a    (chal_a),
        .chal_b    (chal_b),
        .busy      (busy),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .ro_en     (ro_en),
        .cnt_rst   (cnt_rst),
        .count_a   (count_a),
        .count_b   (count_b),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_bit  (resp_bit),
        .resp_tie  (resp_tie),
        .resp_diff (resp_diff),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [SEL_W-1:0] a, input logic [SEL_W-1:0] b);
        chal_a = a;
        chal_b = b;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    // Called right after the accept edge (k=0); walks until resp_valid and profiles
    // ro_en / cnt_rst on the way.
    task automatic wait_resp(input logic [N_RO-1:0] mask, output int lat, output int en_cnt,
                             output int en_first, output int en_last, output int en_bad,
                             output int rst_cnt, output int busy_low);
        lat = -1; en_cnt = 0; en_first = -1; en_last = -1; en_bad = 0;
        rst_cnt = 0; busy_low = 0;
        for (int k = 0; k < 400; k++) begin
            if (resp_valid) begin
                lat = k;
                break;
            end
            if (ro_en != '0) begin
                en_cnt++;
                if (en_first < 0) en_first = k;
                en_last = k;
                if (ro_en != mask) en_bad++;
            end
            if (cnt_rst) rst_cnt++;
            if (!busy) busy_low++;
            step();
        end
    endtask

    task automatic handshake(input string tag);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check_eq({tag, "_hs_valid"}, 32'(resp_valid), 32'd0);
        check_eq({tag, "_hs_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_hs_cnt_rst"}, 32'(cnt_rst), 32'd1);
    endtask

    task automatic check_resp(input string tag, input logic b, input logic t,
                              input logic [CNT_W-1:0] d, input logic e);
        check_eq({tag, "_bit"}, 32'(resp_bit), 32'(b));
        check_eq({tag, "_tie"}, 32'(resp_tie), 32'(t));
        check_eq({tag, "_diff"}, 32'(resp_diff), 32'(d));
        check_eq({tag, "_err"}, 32'(resp_err), 32'(e));
    endtask

    int lat, en_cnt, en_first, en_last, en_bad, rst_cnt, busy_low, unstable;

    initial begin
        rst = 1'b1; start = 1'b0; chal_a = '0; chal_b = '0;
        count_a = '0; count_b = '0; resp_ready = 1'b0;
        repeat (3) step();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_sel_a", 32'(sel_a), 32'd0);
        check_eq("rst_sel_b", 32'(sel_b), 32'd0);
        check_eq("rst_ro_en", 32'(ro_en), 32'd0);
        check_eq("rst_cnt_rst", 32'(cnt_rst), 32'd1);
        check_eq("rst_valid", 32'(resp_valid), 32'd0);
        check_resp("rst", 1'b0, 1'b0, 16'd0, 1'b0);
        rst = 1'b0;
        step();

        // Basic measurement and enable shape
        count_a = 16'd1200; count_b = 16'd1100;
        accept(5'd3, 5'd7);
        check_eq("t1_busy_e0", 32'(busy), 32'd1);
        check_eq("t1_sel_a", 32'(sel_a), 32'd3);
        check_eq("t1_sel_b", 32'(sel_b), 32'd7);
        wait_resp(16'h0088, lat, en_cnt, en_first, en_last, en_bad, rst_cnt, busy_low);
        check_eq("t1_latency", 32'(lat), 32'(LAT));
        check_eq("t2_en_cycles", 32'(en_cnt), 32'd100);
        check_eq("t2_en_first", 32'(en_first), 32'd4);
        check_eq("t2_en_last", 32'(en_last), 32'd103);
        check_eq("t2_en_bad", 32'(en_bad), 32'd0);
        check_eq("t2_rst_cycles", 32'(rst_cnt), 32'd4);
        check_eq("t1_busy_low", 32'(busy_low), 32'd0);
        check_resp("t1", 1'b1, 1'b0, 16'd100, 1'b0);
        handshake("t1");

        // Tie and reverse order
        count_a = 16'd500; count_b = 16'd500;
        accept(5'd0, 5'd15);
        wait_resp(16'h8001, lat, en_cnt, en_first, en_last, en_bad, rst_cnt, busy_low);
        check_eq("t3_tie_latency", 32'(lat), 32'(LAT));
        check_eq("t3_tie_en_bad", 32'(en_bad), 32'd0);
        check_resp("t3_tie", 1'b0, 1'b1, 16'd0, 1'b0);
        handshake("t3_tie");

        count_a = 16'd10; count_b = 16'd65535;
        accept(5'd12, 5'd1);
        wait_resp(16'h1002, lat, en_cnt, en_first, en_last, en_bad, rst_cnt, busy_low);
        check_eq("t3_rev_latency", 32'(lat), 32'(LAT));
        check_resp("t3_rev", 1'b0, 1'b0, 16'd65525, 1'b0);
        handshake("t3_rev");

        // Invalid challenges: equal indices, then out-of-range index
        accept(5'd5, 5'd5);
        wait_resp(16'h0000, lat, en_cnt, en_first, en_last, en_bad, rst_cnt, busy_low);
        check_eq("t4_eq_latency", 32'(lat), 32'd1);
        check_eq("t4_eq_en_cnt", 32'(en_cnt), 32'd0);
        check_resp("t4_eq", 1'b0, 1'b0, 16'd0, 1'b1);
        handshake("t4_eq");

        accept(5'd16, 5'd2);
        wait_resp(16'h0000, lat, en_cnt, en_first, en_last, en_bad, rst_cnt, busy_low);
        check_eq("t4_oor_latency", 32'(lat), 32'd1);
        check_eq("t4_oor_en_cnt", 32'(en_cnt), 32'd0);
        check_resp("t4_oor", 1'b0, 1'b0, 16'd0, 1'b1);
        handshake("t4_oor");

        // Backpressure: hold ready low, pulse start, then ready and start together
        count_a = 16'd40; count_b = 16'd900;
        accept(5'd4, 5'd6);
        wait_resp(16'h0050, lat, en_cnt, en_first, en_last, en_bad, rst_cnt, busy_low);
        check_eq("t5_latency", 32'(lat), 32'(LAT));
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                chal_a = 5'd1; chal_b = 5'd2; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (!resp_valid || resp_bit || resp_tie || resp_diff != 16'd860 || resp_err ||
                sel_a != 5'd4 || sel_b != 5'd6 || ro_en != '0 || cnt_rst || !busy)
                unstable++;
            step();
        end
        check_eq("t5_bp_unstable", 32'(unstable), 32'd0);
        check_resp("t5", 1'b0, 1'b0, 16'd860, 1'b0);
        chal_a = 5'd1; chal_b = 5'd2; start = 1'b1; resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check_eq("t5_hs_valid", 32'(resp_valid), 32'd0);
        check_eq("t5_no_capture_busy", 32'(busy), 32'd0);
        check_eq("t5_no_capture_sel_a", 32'(sel_a), 32'd4);
        step();
        start = 1'b0;
        check_eq("t5_next_busy", 32'(busy), 32'd1);
        check_eq("t5_next_sel_a", 32'(sel_a), 32'd1);
        check_eq("t5_next_sel_b", 32'(sel_b), 32'd2);
        count_a = 16'd77; count_b = 16'd70;
        wait_resp(16'h0006, lat, en_cnt, en_first, en_last, en_bad, rst_cnt, busy_low);
        check_eq("t5_next_latency", 32'(lat), 32'(LAT));
        check_resp("t5_next", 1'b1, 1'b0, 16'd7, 1'b0);
        handshake("t5_next");

        // Reset at cycle 50 of the window
        accept(5'd3, 5'd7);
        repeat (CLR_CYC + 50) step();
        check_eq("t6_pre_ro_en", 32'(ro_en), 32'h0088);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t6_ro_en", 32'(ro_en), 32'd0);
        check_eq("t6_cnt_rst", 32'(cnt_rst), 32'd1);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_valid", 32'(resp_valid), 32'd0);
        check_eq("t6_sel_a", 32'(sel_a), 32'd0);
        count_a = 16'd300; count_b = 16'd301;
        accept(5'd2, 5'd9);
        wait_resp(16'h0204, lat, en_cnt, en_first, en_last, en_bad, rst_cnt, busy_low);
        check_eq("t6_latency", 32'(lat), 32'(LAT));
        check_eq("t6_en_cycles", 32'(en_cnt), 32'd100);
        check_resp("t6", 1'b0, 1'b0, 16'd1, 1'b0);
        handshake("t6");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
